// File: rtl/bridge_pkg.sv
// Shared definitions for the AHB-to-APB bridge: request packet layout,
// APB master state encoding and the data returned by a timed-out read.
package bridge_pkg;

    localparam int PKT_W         = 41;
    localparam int PKT_WRITE_BIT = 40;
    localparam int PKT_DATA_MSB  = 39;
    localparam int PKT_DATA_LSB  = 8;
    localparam int PKT_ADDR_MSB  = 7;

    localparam logic [31:0] TIMEOUT_RD_DATA = 32'h0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_timeout_counter.sv
// Counts ACCESS cycles spent with PREADY low; o_expired flags the last
// cycle a transfer is allowed to wait before being forced to complete.
module apb_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int               CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // Saturates at LAST so a stray enable can never wrap back to zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == LAST);

endmodule

// File: rtl/apb_master_fsm.sv
// APB master back end of the AHB-to-APB bridge: accepts one request packet
// at a time, runs SETUP/ACCESS, and reports read data, slave errors and timeouts.
module apb_master_fsm
    import bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              HCLK,
    input  logic              RESETn,
    input  logic [PKT_W-1:0]  Packet_In,
    input  logic              H_Valid,
    output logic              Bridge_Ready,
    output logic [31:0]       Bridge_Rd_Data,
    output logic              Bridge_Rd_Valid,
    output logic              Bridge_Err,
    output logic [7:0]        PADDR,
    output logic [31:0]       PWDATA,
    output logic              PWRITE,
    output logic              PSEL,
    output logic              PENABLE,
    input  logic [31:0]       PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    apb_state_e  r_state;
    logic        r_ready;
    logic        r_psel;
    logic        r_penable;
    logic        r_pwrite;
    logic        r_rd_valid;
    logic        r_err;
    logic [7:0]  r_paddr;
    logic [31:0] r_pwdata;
    logic [31:0] r_rd_data;

    logic w_cnt_clear;
    logic w_cnt_enable;
    logic w_expired;
    logic w_done;

    assign w_cnt_clear  = (r_state == SETUP);
    assign w_cnt_enable = (r_state == ACCESS) && !PREADY;
    // PREADY wins on the final wait cycle, so that case is a normal completion.
    assign w_done       = PREADY || w_expired;

    apb_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk     (HCLK),
        .i_rst_n   (RESETn),
        .i_clear   (w_cnt_clear),
        .i_enable  (w_cnt_enable),
        .o_expired (w_expired)
    );

    always_ff @(posedge HCLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state    <= IDLE;
            r_ready    <= 1'b0;
            r_psel     <= 1'b0;
            r_penable  <= 1'b0;
            r_pwrite   <= 1'b0;
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
            r_paddr    <= '0;
            r_pwdata   <= '0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (H_Valid && r_ready) begin
                        r_paddr  <= Packet_In[PKT_ADDR_MSB:0];
                        r_pwdata <= Packet_In[PKT_DATA_MSB:PKT_DATA_LSB];
                        r_pwrite <= Packet_In[PKT_WRITE_BIT];
                        r_ready  <= 1'b0;
                        r_psel   <= 1'b1;
                        r_state  <= SETUP;
                    end else begin
                        r_ready  <= 1'b1;
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    if (w_done) begin
                        r_state   <= IDLE;
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_ready   <= 1'b1;
                        r_err     <= PREADY ? PSLVERR : 1'b1;
                        if (!r_pwrite) begin
                            r_rd_valid <= 1'b1;
                            r_rd_data  <= PREADY ? PRDATA : TIMEOUT_RD_DATA;
                        end
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_ready   <= 1'b0;
                end
            endcase
        end
    end

    assign Bridge_Ready    = r_ready;
    assign Bridge_Rd_Data  = r_rd_data;
    assign Bridge_Rd_Valid = r_rd_valid;
    assign Bridge_Err      = r_err;
    assign PADDR           = r_paddr;
    assign PWDATA          = r_pwdata;
    assign PWRITE          = r_pwrite;
    assign PSEL            = r_psel;
    assign PENABLE         = r_penable;

endmodule

// File: tb/tb_apb_master_fsm.sv
// Self-checking bench for apb_master_fsm: directed vector table, randomized
// transfers against a transaction-level model, back-to-back and reset cases.
module tb_apb_master_fsm;

    localparam int TMO = 4;

    logic        HCLK = 1'b0;
    logic        RESETn;
    logic [40:0] Packet_In;
    logic        H_Valid;
    logic        Bridge_Ready;
    logic [31:0] Bridge_Rd_Data;
    logic        Bridge_Rd_Valid;
    logic        Bridge_Err;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] m_rd_data;

    always #5 HCLK = ~HCLK;

    apb_master_fsm #(.TIMEOUT_CYCLES(TMO)) dut (
        .HCLK            (HCLK),
        .RESETn          (RESETn),
        .Packet_In       (Packet_In),
        .H_Valid         (H_Valid),
        .Bridge_Ready    (Bridge_Ready),
        .Bridge_Rd_Data  (Bridge_Rd_Data),
        .Bridge_Rd_Valid (Bridge_Rd_Valid),
        .Bridge_Err      (Bridge_Err),
        .PADDR           (PADDR),
        .PWDATA          (PWDATA),
        .PWRITE          (PWRITE),
        .PSEL            (PSEL),
        .PENABLE         (PENABLE),
        .PRDATA          (PRDATA),
        .PREADY          (PREADY),
        .PSLVERR         (PSLVERR)
    );

    typedef struct {
        logic [40:0] pkt;
        int          waits;
        logic [31:0] prdata;
        logic        slverr;
        logic        exp_valid;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_access;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level view: a transfer lasts waits+1 ACCESS cycles unless
    // PREADY never arrives within TMO cycles, in which case it times out.
    function automatic void model(input logic wr, input int waits, input logic [31:0] prd,
                                  input logic slv, input logic [31:0] prev_rd,
                                  output logic v, output logic e, output logic [31:0] rd,
                                  output int n_acc);
        logic timed;
        timed = (waits >= TMO);
        n_acc = timed ? TMO : waits + 1;
        v     = !wr;
        e     = timed || slv;
        rd    = wr ? prev_rd : (timed ? 32'h0 : prd);
    endfunction

    task automatic wait_ready();
        int guard = 0;
        @(negedge HCLK);
        while (!Bridge_Ready && guard < 50) begin
            @(negedge HCLK);
            guard++;
        end
        chk("ready_wait", Bridge_Ready, 1);
    endtask

    task automatic run_txn(input string name, input logic [40:0] pkt, input int waits,
                           input logic [31:0] prdata, input logic slverr,
                           input logic exp_valid, input logic exp_err,
                           input logic [31:0] exp_rdata, input int n_acc);
        wait_ready();
        Packet_In = pkt;
        H_Valid   = 1'b1;
        PREADY    = 1'b0;
        @(negedge HCLK);
        H_Valid   = 1'b0;
        Packet_In = ~pkt;
        chk({name, "_setup_psel"}, PSEL, 1);
        chk({name, "_setup_penable"}, PENABLE, 0);
        chk({name, "_setup_ready"}, Bridge_Ready, 0);
        chk({name, "_paddr"}, PADDR, pkt[7:0]);
        chk({name, "_pwdata"}, PWDATA, pkt[39:8]);
        chk({name, "_pwrite"}, PWRITE, pkt[40]);
        @(negedge HCLK);
        for (int k = 0; k < n_acc; k++) begin
            chk({name, "_acc_psel"}, PSEL, 1);
            chk({name, "_acc_penable"}, PENABLE, 1);
            chk({name, "_acc_paddr"}, PADDR, pkt[7:0]);
            chk({name, "_acc_rdvalid"}, Bridge_Rd_Valid, 0);
            chk({name, "_acc_err"}, Bridge_Err, 0);
            PREADY  = (k == waits);
            PRDATA  = (k == waits) ? prdata : $urandom;
            PSLVERR = (k == waits) ? slverr : 1'($urandom_range(0, 1));
            @(negedge HCLK);
        end
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        chk({name, "_done_psel"}, PSEL, 0);
        chk({name, "_done_penable"}, PENABLE, 0);
        chk({name, "_done_ready"}, Bridge_Ready, 1);
        chk({name, "_done_rdvalid"}, Bridge_Rd_Valid, exp_valid);
        chk({name, "_done_err"}, Bridge_Err, exp_err);
        chk({name, "_done_rddata"}, Bridge_Rd_Data, exp_rdata);
        $display("txn %s: wr=%0b addr=%02h waits=%0d rd_valid=%0b err=%0b rd_data=%08h",
                 name, pkt[40], pkt[7:0], waits, Bridge_Rd_Valid, Bridge_Err, Bridge_Rd_Data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        bb_psel[6];
        logic        bb_pen[6];
        logic        bb_rdy[6];
        logic [40:0] pkt;
        int          waits;
        logic [31:0] prd;
        logic        slv;
        logic        ev;
        logic        ee;
        logic [31:0] erd;
        int          nacc;

        vecs[0] = '{{1'b1, 32'hA5A5_0001, 8'h10}, 0,  32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1};
        vecs[1] = '{{1'b0, 32'h0,         8'h20}, 3,  32'h1234_5678, 1'b0, 1'b1, 1'b0, 32'h1234_5678, 4};
        vecs[2] = '{{1'b0, 32'h0,         8'h30}, 0,  32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 1};
        vecs[3] = '{{1'b0, 32'h0,         8'h40}, 10, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 32'h0,         4};
        vecs[4] = '{{1'b1, 32'h5555_AAAA, 8'h50}, 4,  32'h0,         1'b0, 1'b0, 1'b1, 32'h0,         4};
        vecs[5] = '{{1'b0, 32'h0,         8'h60}, 1,  32'hCAFE_0001, 1'b0, 1'b1, 1'b0, 32'hCAFE_0001, 2};
        vecs[6] = '{{1'b1, 32'h0BAD_F00D, 8'h70}, 2,  32'h0,         1'b1, 1'b0, 1'b1, 32'hCAFE_0001, 3};

        RESETn    = 1'b0;
        H_Valid   = 1'b0;
        Packet_In = '0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        m_rd_data = '0;

        #12;
        chk("rst_ready", Bridge_Ready, 0);
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_rdvalid", Bridge_Rd_Valid, 0);
        chk("rst_err", Bridge_Err, 0);
        chk("rst_rddata", Bridge_Rd_Data, 0);
        chk("rst_apb", {PADDR, PWDATA, PWRITE}, 0);
        @(negedge HCLK);
        @(negedge HCLK);
        RESETn = 1'b1;
        #1;
        chk("rel_ready_low", Bridge_Ready, 0);

        for (int i = 0; i < 7; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].pkt, vecs[i].waits, vecs[i].prdata,
                    vecs[i].slverr, vecs[i].exp_valid, vecs[i].exp_err,
                    vecs[i].exp_rdata, vecs[i].exp_access);
            m_rd_data = vecs[i].exp_rdata;
        end

        // Back-to-back zero-wait writes with H_Valid held high throughout.
        bb_psel = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        bb_pen  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        bb_rdy  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        wait_ready();
        Packet_In = {1'b1, 32'h1111_1111, 8'hA1};
        H_Valid   = 1'b1;
        PREADY    = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge HCLK);
            chk($sformatf("b2b_psel_%0d", i), PSEL, bb_psel[i]);
            chk($sformatf("b2b_penable_%0d", i), PENABLE, bb_pen[i]);
            chk($sformatf("b2b_ready_%0d", i), Bridge_Ready, bb_rdy[i]);
            chk($sformatf("b2b_rdvalid_%0d", i), Bridge_Rd_Valid, 0);
            if (i == 0) begin
                chk("b2b_paddr_a", PADDR, 8'hA1);
                Packet_In = {1'b1, 32'h2222_2222, 8'hB2};
            end
            if (i == 3) begin
                chk("b2b_paddr_b", PADDR, 8'hB2);
                chk("b2b_pwdata_b", PWDATA, 32'h2222_2222);
                H_Valid = 1'b0;
            end
        end
        PREADY = 1'b0;
        $display("txn b2b: two writes a1/b2 back to back, second accepted one cycle after completion");

        // Reset while a read sits in ACCESS.
        wait_ready();
        Packet_In = {1'b0, 32'h0, 8'h77};
        H_Valid   = 1'b1;
        PREADY    = 1'b0;
        @(negedge HCLK);
        H_Valid = 1'b0;
        @(negedge HCLK);
        @(negedge HCLK);
        chk("mid_penable_before", PENABLE, 1);
        #2;
        RESETn = 1'b0;
        #1;
        chk("mid_rst_psel", PSEL, 0);
        chk("mid_rst_penable", PENABLE, 0);
        chk("mid_rst_ready", Bridge_Ready, 0);
        @(negedge HCLK);
        chk("mid_rst_rdvalid", Bridge_Rd_Valid, 0);
        chk("mid_rst_err", Bridge_Err, 0);
        chk("mid_rst_rddata", Bridge_Rd_Data, 0);
        RESETn    = 1'b1;
        m_rd_data = '0;
        $display("txn reset_mid_access: read to 77 dropped by reset");
        run_txn("post_rst", {1'b0, 32'h0, 8'h78}, 1, 32'h8765_4321, 1'b0,
                1'b1, 1'b0, 32'h8765_4321, 2);
        m_rd_data = 32'h8765_4321;

        for (int i = 0; i < 24; i++) begin
            pkt   = {1'($urandom_range(0, 1)), 32'($urandom), 8'($urandom)};
            waits = $urandom_range(0, TMO + 2);
            prd   = $urandom;
            slv   = 1'($urandom_range(0, 1));
            model(pkt[40], waits, prd, slv, m_rd_data, ev, ee, erd, nacc);
            run_txn($sformatf("rnd%0d", i), pkt, waits, prd, slv, ev, ee, erd, nacc);
            m_rd_data = erd;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/apb_master_fsm.md
# apb_master_fsm

Bridge back end sitting directly downstream of the AHB slave front end. It accepts one 41-bit request packet at a time over a valid/ready handshake, runs the APB SETUP/ACCESS protocol toward the peripheral bus, and returns read data with a one-cycle valid pulse. A programmable ACCESS-phase timeout keeps a hung peripheral from stalling the AHB side forever.

## Interface
- TIMEOUT_CYCLES, 16: maximum ACCESS cycles with PREADY low before forced completion (range 2..255)
- HCLK  in  1  single clock for the whole bridge
- RESETn  in  1  asynchronous, active-low reset
- Packet_In  in  41  request packet: [40] write, [39:8] write data, [7:0] address
- H_Valid  in  1  packet valid; held by the producer until accepted
- Bridge_Ready  out  1  registered; high only in IDLE, meaning a packet can be accepted
- Bridge_Rd_Data  out  32  last read result; holds value until the next read completes
- Bridge_Rd_Valid  out  1  one-cycle pulse on read completion
- Bridge_Err  out  1  one-cycle pulse on completion with PSLVERR or timeout
- PADDR  out  8  APB address
- PWDATA  out  32  APB write data
- PWRITE  out  1  APB direction
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PRDATA  in  32  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB error, sampled only with PREADY or at timeout

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - Bridge_Ready=1.
  - On H_Valid && Bridge_Ready, capture the packet into PADDR, PWDATA and PWRITE.
  - Drive Bridge_Ready to 0 and go to SETUP.
- SETUP:
  - PSEL=1, PENABLE=0.
  - Unconditionally go to ACCESS.
  - Clear the timeout counter.
- ACCESS:
  - PSEL=1, PENABLE=1.
  - If PREADY=1, the transfer completes.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES-1 with PREADY still low, the transfer completes as timed out.
- Completion, applied at the completing edge:
  - Return to IDLE.
  - PSEL=0, PENABLE=0.
  - Bridge_Ready=1.
  - Reads load Bridge_Rd_Data from PRDATA and pulse Bridge_Rd_Valid. A timed-out read loads 32'h0000_0000.
  - Bridge_Err pulses if PSLVERR=1 at completion or on timeout.
- Writes are posted: there is no write-completion signal, and the producer treats acceptance as done.
- PADDR, PWDATA and PWRITE stay stable from SETUP through completion, and hold their values in IDLE.
- H_Valid while Bridge_Ready=0 is ignored; the packet is taken at the next IDLE.
- Reset values:
  - All outputs 0, including Bridge_Ready.
  - State IDLE.
  - Bridge_Ready rises on the first edge after RESETn deasserts.

## Timing
- Accept edge E0.
- SETUP cycle between E0 and E1.
- First ACCESS cycle between E1 and E2.
- Zero-wait transfer:
  - Completes at E2.
  - Bridge_Rd_Valid/Bridge_Err high for the cycle after E2.
  - Bridge_Ready high after E2.
  - Occupancy is 2 cycles per transfer.
- Each PREADY-low ACCESS cycle adds 1 cycle, up to TIMEOUT_CYCLES ACCESS cycles in total.
- Back-to-back transfers: a new packet can be accepted at the edge after completion, giving a 3-cycle minimum per transfer.
- Completion and acceptance never coincide, because Bridge_Ready is low during completion.
- Reset mid-transfer:
  - PSEL and PENABLE drop asynchronously.
  - No Rd_Valid or Err pulse is issued.
  - The in-flight packet is lost.
- PREADY=1 on the timeout cycle counts as normal completion, not a timeout.

## Structure
- Shared package bridge_pkg holds:
  - Packet field positions: PKT_W=41, PKT_WRITE_BIT=40, PKT_DATA_MSB=39, PKT_DATA_LSB=8, PKT_ADDR_MSB=7.
  - The state encoding (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2).
  - TIMEOUT_RD_DATA=32'h0.
- One sub-module, apb_timeout_counter:
  - clear input, enable input, expired output.
  - Width is clog2(TIMEOUT_CYCLES).

## Test plan
- Zero-wait write: packet {1, 32'hA5A5_0001, 8'h10}, PREADY=1 → PSEL high for 2 cycles, PENABLE in the 2nd, PADDR=8'h10, PWDATA=32'hA5A5_0001, no Rd_Valid, Bridge_Ready back after 2 cycles.
- Read with 3 wait states: PRDATA=32'h1234_5678 with PREADY asserted in the 4th ACCESS cycle → Bridge_Rd_Data=32'h1234_5678, Rd_Valid one cycle, Err=0.
- Slave error: read with PSLVERR=1 on completion → Bridge_Err and Rd_Valid pulse together.
- Timeout: TIMEOUT_CYCLES=4, PREADY held low → completion after 4 ACCESS cycles, Rd_Data=0, Err pulse, APB idle.
- Back-to-back: H_Valid held high with two packets → second accepted exactly 1 cycle after the first completes, no overlap of PSEL.
- Reset during ACCESS: RESETn low → PSEL/PENABLE/Bridge_Ready 0 immediately; after release, Bridge_Ready=1 and a fresh read completes normally.
